// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a small scancode FIFO.
// Synchronises the PS/2 clock and data pads, deserialises 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and buffers {perr, byte} entries.
// Firmware polls data_out and pops with sel & rd; sel & we clears the sticky flags.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   PS2_CLK   PS/2 clock pad (asynchronous)
//   PS2_DATA  PS/2 data pad (asynchronous)
//   sel       peripheral select; qualifies rd and we
//   we        clear sticky overflow / frame_err flags
//   rd        pop the FIFO head
//   data_out  {0, frame_err, overflow, perr, valid, byte}, registered
module ps2_rx_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PS2_CLK,
  input  logic              PS2_DATA,
  input  logic              sel,
  input  logic              we,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned PtrW  = FIFO_AW + 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Pad synchronisers
  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       ps2_clk_s, data_sync, fall;

  // Frame FSM
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            perr_q, perr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            push_q, push_d;
  logic [8:0]      push_data_q, push_data_d;
  logic            frame_err_set;

  // FIFO and status
  logic [8:0]      mem [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic            empty, full, pop, wr_en, ovf_set, flag_clr;
  logic            ovf_q, ovf_d, frame_err_q, frame_err_d;
  logic [8:0]      head;
  logic [DATA_W-1:0] data_out_d;

  assign ps2_clk_s = clk_sync_q[1];
  assign data_sync = data_sync_q[1];
  assign fall      = clk_prev_q & ~ps2_clk_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
      data_sync_q <= {data_sync_q[0], PS2_DATA};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    perr_d        = perr_q;
    push_d        = 1'b0;
    push_data_d   = push_data_q;
    frame_err_set = 1'b0;
    tmo_d         = (fall || state_q == StIdle) ? '0 : tmo_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        // A high data line at a clock fall is a glitch, not a start bit
        if (fall && !data_sync) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          perr_d  = ~(^{shift_q, data_sync});
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (data_sync) begin
            push_d      = 1'b1;
            push_data_d = {perr_q, shift_q};
          end else begin
            frame_err_set = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stalled frame: abandon the partial byte
    if (state_q != StIdle && !fall && tmo_q == TmoMax) begin
      state_d       = StIdle;
      shift_d       = '0;
      frame_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
               (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    pop      = sel & rd & ~empty;
    // A pop in the same cycle frees the slot the push needs
    wr_en    = push_q & (~full | pop);
    ovf_set  = push_q & full & ~pop;
    flag_clr = sel & we;
    wptr_d   = wptr_q + PtrW'(wr_en);
    rptr_d   = rptr_q + PtrW'(pop);
    // Set beats a simultaneous clear
    ovf_d       = ovf_set | (ovf_q & ~flag_clr);
    frame_err_d = frame_err_set | (frame_err_q & ~flag_clr);
    head        = mem[rptr_q[FIFO_AW-1:0]];

    data_out_d     = '0;
    data_out_d[11] = frame_err_q;
    data_out_d[10] = ovf_q;
    if (!empty) begin
      data_out_d[9]   = head[8];
      data_out_d[8]   = 1'b1;
      data_out_d[7:0] = head[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[FIFO_AW-1:0]] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
      data_out    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
      data_out    <= data_out_d;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int unsigned Tmo  = 200;
  localparam int unsigned Half = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] data_out;

  int checks = 0;
  int passes = 0;

  ps2_rx_fifo #(
    .DATA_W     (32),
    .FIFO_AW    (2),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .PS2_CLK (ps2_clk),
    .PS2_DATA(ps2_data),
    .sel     (sel),
    .we      (we),
    .rd      (rd),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        bad_par;
    logic        stop;
    logic        act_pop;   // 1: pop afterwards, 0: clear flags afterwards
    logic [31:0] exp_frame;
    logic [31:0] exp_act;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (data_out === exp) passes++;
    else $display("FAIL %s: data_out=0x%03h expected 0x%03h", name, data_out, exp);
  endtask

  // Send the first n bits of a frame; device changes data while the clock is high
  task automatic send_bits(input logic [7:0] data, input logic bad_par, input logic stop,
                           input int n);
    logic [10:0] bits;
    logic        par;
    par  = ~(^data) ^ bad_par;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic strobe(input logic do_rd, input logic do_we, input logic do_sel);
    @(negedge clk);
    sel = do_sel;
    rd  = do_rd;
    we  = do_we;
    @(negedge clk);
    sel = 1'b0;
    rd  = 1'b0;
    we  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 32'h11C, 32'h000};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 32'h3F0, 32'h000};
    vecs[2] = '{8'h33, 1'b0, 1'b0, 1'b0, 32'h800, 32'h000};

    repeat (3) @(negedge clk);
    check("reset", 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      send_bits(vecs[v].data, vecs[v].bad_par, vecs[v].stop, 11);
      check($sformatf("vec%0d_frame", v), vecs[v].exp_frame);
      if (vecs[v].act_pop) strobe(1'b1, 1'b0, 1'b1);
      else strobe(1'b0, 1'b1, 1'b1);
      check($sformatf("vec%0d_after", v), vecs[v].exp_act);
    end

    // Overflow: five frames into a depth-4 FIFO
    for (int b = 1; b <= 5; b++) send_bits(8'(b), 1'b0, 1'b1, 11);
    check("ovf_head", 32'h501);
    strobe(1'b1, 1'b1, 1'b0);
    check("unselected_ignored", 32'h501);
    for (int b = 2; b <= 4; b++) begin
      strobe(1'b1, 1'b0, 1'b1);
      check($sformatf("ovf_pop_head%0d", b), 32'h500 | 32'(b));
    end
    strobe(1'b1, 1'b0, 1'b1);
    check("ovf_drained", 32'h400);
    strobe(1'b0, 1'b1, 1'b1);
    check("ovf_cleared", 32'h000);

    // Timeout after start + 4 data bits
    send_bits(8'hA5, 1'b0, 1'b1, 5);
    repeat (Tmo + 20) @(negedge clk);
    check("timeout_err", 32'h800);
    send_bits(8'h5A, 1'b0, 1'b1, 11);
    check("after_timeout", 32'h95A);
    strobe(1'b1, 1'b0, 1'b1);
    check("timeout_pop", 32'h800);
    strobe(1'b0, 1'b1, 1'b1);
    check("timeout_clear", 32'h000);

    // Reset mid-frame after start + 6 data bits
    send_bits(8'hC3, 1'b0, 1'b1, 7);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset_held", 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_released", 32'h0);
    send_bits(8'h29, 1'b0, 1'b1, 11);
    check("fresh_frame", 32'h129);
    strobe(1'b1, 1'b0, 1'b1);
    check("pop_last", 32'h000);
    strobe(1'b1, 1'b0, 1'b1);
    check("pop_empty1", 32'h000);
    strobe(1'b1, 1'b0, 1'b1);
    check("pop_empty2", 32'h000);
    send_bits(8'h77, 1'b0, 1'b1, 11);
    check("ptrs_intact", 32'h177);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
